// File: rtl/conv_3x3_mac.sv
// Purpose: 3x3 signed fixed-point convolution of a window-buffer beat against a double-buffered kernel plus bias.
// Latency: 4 cycles from the edge that samples valid_in to valid_out/out; one beat per cycle.
// Backpressure: none on the pixel path (pipeline never stalls); weight_ready throttles coefficient writes.
//
// Ports:
//   clk, reset          single clock; asynchronous active-low reset clearing all state
//   valid_in            nine window pixels pxl_in_00..pxl_in_08 (row-major) are valid this cycle
//   load_weights        commit strobe from the window buffer (row boundary)
//   weight_valid/_in    coefficient write stream w00..w08 then bias; accepted while weight_ready
//   weight_ready        shadow bank has room for another coefficient
//   weights_loaded      the active bank has been committed at least once since reset
//   out, valid_out      rounded, saturated result; out is 0 whenever valid_out is 0
module conv_3x3_mac #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in_00,
    input  logic [DATA_WIDTH-1:0] pxl_in_01,
    input  logic [DATA_WIDTH-1:0] pxl_in_02,
    input  logic [DATA_WIDTH-1:0] pxl_in_03,
    input  logic [DATA_WIDTH-1:0] pxl_in_04,
    input  logic [DATA_WIDTH-1:0] pxl_in_05,
    input  logic [DATA_WIDTH-1:0] pxl_in_06,
    input  logic [DATA_WIDTH-1:0] pxl_in_07,
    input  logic [DATA_WIDTH-1:0] pxl_in_08,
    input  logic                  load_weights,
    input  logic                  weight_valid,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic                  weight_ready,
    output logic                  weights_loaded,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  valid_out
);

    localparam int         PW        = 2*DATA_WIDTH;   // full product width
    localparam int         NTAP      = 9;
    localparam int         NCOEF     = NTAP + 1;       // nine taps plus bias
    localparam logic [3:0] WCNT_FULL = 4'd10;

    // Rounding constant (one half LSB of the output) and saturation bounds in accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] RND =
        {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic signed [PW-1:0] sext_pw(input logic [DATA_WIDTH-1:0] v);
        return {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sext_acc(input logic [PW-1:0] v);
        return {{(ACC_WIDTH-PW){v[PW-1]}}, v};
    endfunction

    // Bias is in Q.FRAC; products are in Q.2*FRAC, so the bias is shifted up to line up.
    function automatic logic signed [ACC_WIDTH-1:0] bias_align(input logic [DATA_WIDTH-1:0] b);
        logic signed [ACC_WIDTH-1:0] t;
        t = {{(ACC_WIDTH-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
        return t <<< FRAC_BITS;
    endfunction

    // ------------------------------------------------------------------
    // Coefficient banks
    // ------------------------------------------------------------------
    logic [3:0]            wcnt;
    logic [DATA_WIDTH-1:0] shadow_q [NCOEF];
    logic [DATA_WIDTH-1:0] active_q [NCOEF];
    logic                  wr_en;
    logic                  commit;

    assign weight_ready = (wcnt != WCNT_FULL);
    assign wr_en        = weight_valid & weight_ready;
    // A partially filled shadow bank is never committed; the strobe is simply dropped.
    assign commit       = load_weights & (wcnt == WCNT_FULL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt <= '0;
            for (int i = 0; i < NCOEF; i++) shadow_q[i] <= '0;
        end else if (commit) begin
            wcnt <= '0;
        end else if (wr_en) begin
            shadow_q[wcnt] <= weight_in;
            wcnt           <= wcnt + 4'd1;
        end
    end

    // The active bank updates at the commit edge, so a beat sampled on that same
    // edge still multiplies against the previous coefficients.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            weights_loaded <= 1'b0;
            for (int i = 0; i < NCOEF; i++) active_q[i] <= '0;
        end else if (commit) begin
            weights_loaded <= 1'b1;
            for (int i = 0; i < NCOEF; i++) active_q[i] <= shadow_q[i];
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: nine signed products plus bias copy
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] pxl [NTAP];
    assign pxl[0] = pxl_in_00;
    assign pxl[1] = pxl_in_01;
    assign pxl[2] = pxl_in_02;
    assign pxl[3] = pxl_in_03;
    assign pxl[4] = pxl_in_04;
    assign pxl[5] = pxl_in_05;
    assign pxl[6] = pxl_in_06;
    assign pxl[7] = pxl_in_07;
    assign pxl[8] = pxl_in_08;

    logic signed [PW-1:0]  prod_d [NTAP];
    logic signed [PW-1:0]  prod_q [NTAP];
    logic [DATA_WIDTH-1:0] bias_q1;
    logic                  v1_q;

    // Both operands are sign-extended to the full product width, so the low PW
    // bits of the product are the exact signed result.
    always_comb begin
        for (int i = 0; i < NTAP; i++) begin
            prod_d[i] = sext_pw(pxl[i]) * sext_pw(active_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q    <= 1'b0;
            bias_q1 <= '0;
            for (int i = 0; i < NTAP; i++) prod_q[i] <= '0;
        end else begin
            v1_q    <= valid_in;
            bias_q1 <= valid_in ? active_q[NTAP] : '0;
            for (int i = 0; i < NTAP; i++) prod_q[i] <= valid_in ? prod_d[i] : '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: row sums in accumulator width
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] row_d [3];
    logic signed [ACC_WIDTH-1:0] row_q [3];
    logic [DATA_WIDTH-1:0]       bias_q2;
    logic                        v2_q;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            row_d[r] = sext_acc(prod_q[3*r]) + sext_acc(prod_q[3*r+1]) + sext_acc(prod_q[3*r+2]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2_q    <= 1'b0;
            bias_q2 <= '0;
            for (int r = 0; r < 3; r++) row_q[r] <= '0;
        end else begin
            v2_q    <= v1_q;
            bias_q2 <= v1_q ? bias_q1 : '0;
            for (int r = 0; r < 3; r++) row_q[r] <= v1_q ? row_d[r] : '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: final accumulate with aligned bias
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        v3_q;

    assign acc_d = row_q[0] + row_q[1] + row_q[2] + bias_align(bias_q2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v3_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            v3_q  <= v2_q;
            acc_q <= v2_q ? acc_d : '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: round half toward +inf, rescale, saturate
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] rounded;
    logic signed [ACC_WIDTH-1:0] scaled;
    logic [DATA_WIDTH-1:0]       sat_d;

    always_comb begin
        rounded = acc_q + RND;
        scaled  = rounded >>> FRAC_BITS;
        if (scaled > SAT_MAX) begin
            sat_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (scaled < SAT_MIN) begin
            sat_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat_d = scaled[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            out       <= '0;
        end else begin
            valid_out <= v3_q;
            out       <= v3_q ? sat_d : '0;
        end
    end

endmodule

// File: tb/tb_conv_3x3_mac.sv
// Purpose: self-checking bench for conv_3x3_mac; directed steps with a timestamped scoreboard.
// Latency: expects each result exactly 4 edges after the beat's sampling edge.
// Backpressure: exercises weight_ready around shadow-bank fill and commit.
module tb_conv_3x3_mac;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] px [9];
    logic        load_weights;
    logic        weight_valid;
    logic [31:0] weight_in;
    logic        weight_ready;
    logic        weights_loaded;
    logic [31:0] dout;
    logic        valid_out;

    conv_3x3_mac #(.DATA_WIDTH(32), .FRAC_BITS(16), .ACC_WIDTH(68)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .pxl_in_00      (px[0]),
        .pxl_in_01      (px[1]),
        .pxl_in_02      (px[2]),
        .pxl_in_03      (px[3]),
        .pxl_in_04      (px[4]),
        .pxl_in_05      (px[5]),
        .pxl_in_06      (px[6]),
        .pxl_in_07      (px[7]),
        .pxl_in_08      (px[8]),
        .load_weights   (load_weights),
        .weight_valid   (weight_valid),
        .weight_in      (weight_in),
        .weight_ready   (weight_ready),
        .weights_loaded (weights_loaded),
        .out            (dout),
        .valid_out      (valid_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [31:0] wbank [10];
    logic [31:0] act   [10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Output monitor: every valid result must match the oldest expectation on its due cycle.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (valid_out === 1'b1) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_valid: got out=%h at cycle %0d, expected no output", dout, cyc);
                end
                if (sb.size() > 0) begin : pop_blk
                    exp_t e;
                    e = sb.pop_front();
                    check("out_value", dout, e.val);
                    check("out_latency", cyc, e.due);
                end
            end else begin
                check("out_idle_zero", dout, 32'h0);
                if (sb.size() > 0) begin
                    checks++;
                    assert (cyc <= sb[0].due) else begin
                        errors++;
                        $error("FAIL missing_output: got nothing by cycle %0d, expected %h due at %0d",
                               cyc, sb[0].val, sb[0].due);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // Reference result for arbitrary pixels against the bench's copy of the active bank.
    function automatic logic [31:0] model();
        logic signed [79:0] acc;
        logic signed [79:0] a;
        logic signed [79:0] b;
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            a   = {{48{px[i][31]}}, px[i]};
            b   = {{48{act[i][31]}}, act[i]};
            acc = acc + a * b;
        end
        a   = {{48{act[9][31]}}, act[9]};
        acc = acc + (a <<< 16) + 80'sd32768;
        acc = acc >>> 16;
        if (acc > 80'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (acc < -80'sh8000_0000) return 32'h8000_0000;
        return acc[31:0];
    endfunction

    task automatic idle(input int n);
        valid_in     = 1'b0;
        load_weights = 1'b0;
        weight_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_px(input logic [31:0] v);
        for (int i = 0; i < 9; i++) px[i] = v;
    endtask

    task automatic set_bank(input logic [31:0] w, input logic [31:0] bias);
        for (int i = 0; i < 9; i++) wbank[i] = w;
        wbank[9] = bias;
    endtask

    task automatic send(input logic [31:0] want);
        valid_in = 1'b1;
        sb.push_back(exp_t'{want, cyc + 4});
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic load_bank();
        check("ready_before_fill", weight_ready, 32'h1);
        for (int i = 0; i < 10; i++) begin
            weight_valid = 1'b1;
            weight_in    = wbank[i];
            @(negedge clk);
        end
        weight_valid = 1'b0;
        check("ready_low_when_full", weight_ready, 32'h0);
        load_weights = 1'b1;
        @(negedge clk);
        load_weights = 1'b0;
        check("ready_after_commit", weight_ready, 32'h1);
        check("weights_loaded_set", weights_loaded, 32'h1);
        for (int i = 0; i < 10; i++) act[i] = wbank[i];
    endtask

    initial begin
        reset        = 1'b1;
        valid_in     = 1'b0;
        load_weights = 1'b0;
        weight_valid = 1'b0;
        weight_in    = '0;
        set_px(32'h0);
        for (int i = 0; i < 10; i++) act[i] = '0;

        // Reset values
        #3 reset = 1'b0;
        #1;
        check("rst_valid_out", valid_out, 32'h0);
        check("rst_out", dout, 32'h0);
        check("rst_weights_loaded", weights_loaded, 32'h0);
        check("rst_weight_ready", weight_ready, 32'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(1);

        // Basic convolution: 9 * (2.0 * 1.0) = 18.0
        set_bank(32'h0001_0000, 32'h0);
        load_bank();
        set_px(32'h0002_0000);
        send(32'h0012_0000);
        idle(6);

        // Negative weight and bias: -1.0 * 3.0 + 0.5 = -2.5
        set_bank(32'h0, 32'h0000_8000);
        wbank[4] = 32'hFFFF_0000;
        load_bank();
        set_px(32'h0);
        px[4] = 32'h0003_0000;
        send(32'hFFFD_8000);
        idle(2);

        // Positive and negative saturation, then round-half-up of 0.5 LSB
        set_bank(32'h7FFF_0000, 32'h7FFF_0000);
        load_bank();
        set_px(32'h7FFF_0000);
        send(32'h7FFF_FFFF);
        set_bank(32'h8000_0000, 32'h8000_0000);
        load_bank();
        send(32'h8000_0000);
        set_bank(32'h0, 32'h0);
        wbank[0] = 32'h0000_8000;
        load_bank();
        set_px(32'h0);
        px[0] = 32'h0000_0001;
        send(32'h0000_0001);
        idle(6);

        // Bank swap mid-stream: A = all 1.0 / bias 0, B = all 2.0 / bias 2.0
        set_bank(32'h0001_0000, 32'h0);
        load_bank();
        idle(2);
        for (int c = -3; c <= 13; c++) begin
            weight_valid = (c <= 6);
            weight_in    = 32'h0002_0000;
            load_weights = (c == 7);
            if (c == 7) check("swap_ready_low", weight_ready, 32'h0);
            if (c == 8) check("swap_ready_high", weight_ready, 32'h1);
            if (c >= 0) begin
                valid_in = 1'b1;
                set_px(32'(c) << 16);
                sb.push_back(exp_t'{(c <= 7) ? (32'(9 * c) << 16) : (32'(18 * c + 2) << 16), cyc + 4});
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
        end
        set_bank(32'h0002_0000, 32'h0002_0000);
        for (int i = 0; i < 10; i++) act[i] = wbank[i];
        idle(6);

        // Commit after only five writes is ignored
        for (int i = 0; i < 5; i++) begin
            weight_valid = 1'b1;
            weight_in    = 32'h0003_0000;
            @(negedge clk);
        end
        weight_valid = 1'b0;
        load_weights = 1'b1;
        @(negedge clk);
        load_weights = 1'b0;
        check("partial_ready", weight_ready, 32'h1);
        set_px(32'h0001_0000);
        send(32'h0014_0000);
        for (int i = 0; i < 5; i++) begin
            weight_valid = 1'b1;
            weight_in    = (i == 4) ? 32'h0001_0000 : 32'h0003_0000;
            @(negedge clk);
        end
        weight_valid = 1'b0;
        check("partial_kept_full", weight_ready, 32'h0);
        load_weights = 1'b1;
        @(negedge clk);
        load_weights = 1'b0;
        set_bank(32'h0003_0000, 32'h0001_0000);
        for (int i = 0; i < 10; i++) act[i] = wbank[i];
        send(32'h001C_0000);
        idle(6);

        // Gapped beats with arbitrary signed pixels
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 9; i++) px[i] = 32'($urandom_range(0, 32'h80000)) - 32'h40000;
            send(model());
            idle($urandom_range(0, 2));
        end
        idle(6);

        // Asynchronous reset between edges with beats in flight
        set_px(32'h0001_0000);
        valid_in = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 check("pre_reset_valid", valid_out, 32'h1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_valid_out", valid_out, 32'h0);
        check("mid_rst_out", dout, 32'h0);
        check("mid_rst_weights_loaded", weights_loaded, 32'h0);
        check("mid_rst_weight_ready", weight_ready, 32'h1);
        sb.delete();
        valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) act[i] = '0;
        idle(3);
        send(model());
        idle(6);
        check("post_rst_weights_loaded", weights_loaded, 32'h0);
        set_bank(32'h0001_0000, 32'h0);
        load_bank();
        set_px(32'h0001_0000);
        send(32'h0009_0000);
        idle(8);

        check("scoreboard_drained", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
